div_issue: RTL
==============

DIV_ISSUE -- requirements
Module: div_issue

Interface
REQ-001 SHALL have parameter CACHE_EN, default 1; when 1, enables the single-entry result cache.
REQ-002 SHALL have port clk, input, 1, the single clock; all logic is on the rising edge.
REQ-003 SHALL have port rst_n, input, 1, the reset; it is synchronous and active-high (1 = reset).
REQ-004 SHALL have port ex_valid_i, input, 1, EX-stage instruction valid.
REQ-005 SHALL have port ex_is_div_i, input, 1, EX instruction is DIV/DIVU/REM/REMU.
REQ-006 SHALL have port ex_op_code_i, input, 3, M-extension op code using the `DIV/`DIVU/`REM/`REMU defines.
REQ-007 SHALL have ports ex_rs1_data_i and ex_rs2_data_i, input, 32 each, dividend and divisor.
REQ-008 SHALL have port ex_rd_addr_i, input, 5, destination register.
REQ-009 SHALL have port flush_i, input, 1, pipeline flush (jump/branch/trap).
REQ-010 SHALL have port div_req_o, output, 1, request to the divider.
REQ-011 SHALL have ports div_data1_o and div_data2_o, output, 32 each, plus div_op_code_o, output, 3, and div_reg_wr_addr_o, output, 5; all are registered request payload.
REQ-012 SHALL have port div_busy_i, input, 1, divider busy.
REQ-013 SHALL have port div_res_ready_i, input, 1, divider one-cycle result pulse.
REQ-014 SHALL have port div_res_i, input, 32, divider result.
REQ-015 SHALL have port hold_o, output, 1, pipeline stall request.
REQ-016 SHALL have ports wb_we_o, output, 1; wb_addr_o, output, 5; and wb_data_o, output, 32; these form the register-file write-back.

Function
REQ-017 SHALL implement states IDLE, REQ, WAIT, DONE and DRAIN.
REQ-018 IDLE accept: accept fires when ex_valid_i & ex_is_div_i & !flush_i & !div_busy_i; on accept SHALL capture the operands, op code and rd.
  - Cache miss: next state REQ.
  - Cache hit: next state DONE, with wb_data_o taken from the cache.
REQ-019 Cache hit SHALL mean CACHE_EN=1, cache valid, and exact match of op code, rs1 and rs2.
REQ-020 REQ SHALL drive div_req_o=1 for exactly one cycle with the captured payload, then go to WAIT.
REQ-021 Flush in REQ SHALL suppress div_req_o (div_req_o = REQ & !flush_i) and return to IDLE.
REQ-022 WAIT on div_res_ready_i=1 SHALL:
  - latch div_res_i into wb_data_o;
  - write the cache entry (op, rs1, rs2, result, valid=1);
  - go to DONE.
REQ-023 WAIT with flush_i=1 SHALL go to DRAIN; a simultaneous flush_i and div_res_ready_i is treated as flush (no cache write, go to IDLE).
REQ-024 DRAIN SHALL discard the result and not update the cache; it returns to IDLE the cycle after div_res_ready_i=1.
REQ-025 DONE SHALL drive wb_we_o = !flush_i for one cycle, with wb_addr_o equal to the captured rd, then go to IDLE.
REQ-026 hold_o SHALL be combinational:
  - 1 in IDLE when ex_valid_i & ex_is_div_i & !flush_i;
  - 1 in REQ and WAIT;
  - 1 in DRAIN when ex_valid_i & ex_is_div_i;
  - 0 in DONE, so the pipeline advances in the write-back cycle.
REQ-027 Latency: wb_we_o is asserted the cycle after div_res_ready_i on a miss, and 1 cycle after accept on a hit.
REQ-028 The block SHALL NOT issue a new request while div_busy_i=1 or while in any state other than IDLE.
REQ-029 The block SHALL pass results through unmodified (divide-by-zero and sign handling belong to the divider).
REQ-030 A div_reg_wr_addr_i that differs from the captured rd SHALL be ignored; wb_addr_o always uses the captured rd.

Reset
REQ-031 On rst_n=1 at a clock edge the block SHALL:
  - go to IDLE and invalidate the cache;
  - drive div_req_o=0, wb_we_o=0, hold_o=0;
  - clear wb_data_o, wb_addr_o, div_data1_o, div_data2_o, div_op_code_o and div_reg_wr_addr_o to 0.
REQ-032 Reset mid-operation (REQ/WAIT/DRAIN) SHALL abandon the operation with no write-back; a divider result pulse arriving after reset is ignored.

Verification
REQ-033 DIVU 100/7, rd=5, with a 33-cycle divider model -> one div_req_o pulse; hold_o high until DONE; wb_we_o=1, wb_addr_o=5, wb_data_o=14 the cycle after ready.
REQ-034 Repeat DIVU 100/7, rd=6 -> no div_req_o; wb_we_o=1, wb_data_o=14, wb_addr_o=6 one cycle after accept; with CACHE_EN=0 -> full divider round trip.
REQ-035 REM 0xFFFFFFF9 % 2, model returning 0xFFFFFFFF -> wb_data_o=0xFFFFFFFF; then DIV x/0 with model returning 0xFFFFFFFF -> write-back of 0xFFFFFFFF, cache entry updated.
REQ-036 Flush 5 cycles into WAIT -> DRAIN, hold_o=0, no wb_we_o, cache unchanged.
  - A new DIV presented during DRAIN holds until ready, then issues from IDLE.
REQ-037 Flush coincident with div_res_ready_i, then a flush during DONE -> neither case produces a wb_we_o pulse.
REQ-038 rst_n=1 in WAIT -> all outputs 0 next cycle; a later ready pulse produces no write-back; the next identical op misses the cache.

Source files
------------

// File: rtl/div_issue.sv
// div_issue: issues DIV/DIVU/REM/REMU to an external divider and writes the result back, with a single-entry result cache
`ifndef DIV
`define DIV 3'b100
`endif
`ifndef DIVU
`define DIVU 3'b101
`endif
`ifndef REM
`define REM 3'b110
`endif
`ifndef REMU
`define REMU 3'b111
`endif

module div_issue #(
  parameter bit CACHE_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ex_valid_i,
  input  logic        ex_is_div_i,
  input  logic [2:0]  ex_op_code_i,
  input  logic [31:0] ex_rs1_data_i,
  input  logic [31:0] ex_rs2_data_i,
  input  logic [4:0]  ex_rd_addr_i,
  input  logic        flush_i,
  output logic        div_req_o,
  output logic [31:0] div_data1_o,
  output logic [31:0] div_data2_o,
  output logic [2:0]  div_op_code_o,
  output logic [4:0]  div_reg_wr_addr_o,
  input  logic        div_busy_i,
  input  logic        div_res_ready_i,
  input  logic [31:0] div_res_i,
  output logic        hold_o,
  output logic        wb_we_o,
  output logic [4:0]  wb_addr_o,
  output logic [31:0] wb_data_o
);
  typedef enum logic [2:0] {IDLE, REQ, WAIT, DONE, DRAIN} state_t;
  state_t state, state_nx;
  logic ex_div, acc, hit, c_vld;
  logic [2:0] c_op;
  logic [31:0] c_a, c_b, c_res;
  assign ex_div = ex_valid_i & ex_is_div_i;
  assign acc = (state == IDLE) & ex_div & ~flush_i & ~div_busy_i;
  assign hit = CACHE_EN & c_vld & (c_op == ex_op_code_i) & (c_a == ex_rs1_data_i) & (c_b == ex_rs2_data_i);
  assign wb_addr_o = div_reg_wr_addr_o;
  // next state and strobes; a flush coinciding with the result wins, and reset forces every strobe low
  always_comb begin
    state_nx = state;
    hold_o = 1'b0;
    div_req_o = 1'b0;
    wb_we_o = 1'b0;
    case (state)
      IDLE: begin
        state_nx = acc ? (hit ? DONE : REQ) : IDLE;
        hold_o = ex_div & ~flush_i;
      end
      REQ: begin
        state_nx = flush_i ? IDLE : WAIT;
        hold_o = 1'b1;
        div_req_o = ~flush_i;
      end
      WAIT: begin
        state_nx = flush_i ? (div_res_ready_i ? IDLE : DRAIN) : (div_res_ready_i ? DONE : WAIT);
        hold_o = 1'b1;
      end
      DONE: begin
        state_nx = IDLE;
        wb_we_o = ~flush_i;
      end
      DRAIN: begin
        state_nx = div_res_ready_i ? IDLE : DRAIN;
        hold_o = ex_div;
      end
      default: state_nx = IDLE;
    endcase
    if (rst_n) begin
      hold_o = 1'b0;
      div_req_o = 1'b0;
      wb_we_o = 1'b0;
    end
  end
  // state register, captured request payload, write-back data and cache entry
  always_ff @(posedge clk) begin
    if (rst_n) begin
      state <= IDLE;
      c_vld <= 1'b0;
      div_data1_o <= '0;
      div_data2_o <= '0;
      div_op_code_o <= '0;
      div_reg_wr_addr_o <= '0;
      wb_data_o <= '0;
    end else begin
      state <= state_nx;
      if (acc) begin
        div_data1_o <= ex_rs1_data_i;
        div_data2_o <= ex_rs2_data_i;
        div_op_code_o <= ex_op_code_i;
        div_reg_wr_addr_o <= ex_rd_addr_i;
        if (hit) wb_data_o <= c_res;
      end
      if (state == WAIT && div_res_ready_i && !flush_i) begin
        wb_data_o <= div_res_i;
        c_vld <= 1'b1;
        c_op <= div_op_code_o;
        c_a <= div_data1_o;
        c_b <= div_data2_o;
        c_res <= div_res_i;
      end
    end
  end
endmodule
